// File: rtl/jk_counter_bank.sv
// Bank of WIDTH JK-behaviour state bits that also acts as a wrap-limited up/down counter or a parallel load register.
// Latency: q and wrap update one clk edge after the inputs are sampled; tc is combinational from the current q and controls.
// No backpressure: en low freezes q and clears wrap; every other input may change on any cycle.
module jk_counter_bank #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             up,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_JK    = 2'b01,
    MODE_COUNT = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  // Next edge wraps: up from MAX_COUNT or above (over-range loads wrap too), or down from zero.
  assign tc   = en && (mode == MODE_COUNT) && (up ? (q >= MAX_Q) : (q == '0));
  assign qbar = ~q;

  // Next-state selection by mode; wrap is only ever raised by a wrapping count step.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK: begin
          // Per bit: 00 hold, 10 set, 01 clear, 11 toggle.
          q_nxt = (j & ~q) | (~k & q);
        end
        MODE_COUNT: begin
          if (up) begin
            if (q >= MAX_Q) begin
              q_nxt    = '0;
              wrap_nxt = 1'b1;
            end else begin
              q_nxt = q + WIDTH'(1);
            end
          end else begin
            if (q == '0) begin
              q_nxt    = MAX_Q;
              wrap_nxt = 1'b1;
            end else begin
              q_nxt = q - WIDTH'(1);
            end
          end
        end
        MODE_LOAD: begin
          q_nxt = j;
        end
        default: begin
          q_nxt = q;
        end
      endcase
    end
  end

  // State register; reset wins over everything and drops any pending wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= RST_Q;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_jk_counter_bank.sv
// Self-checking bench for jk_counter_bank (WIDTH=8, MAX_COUNT=9, RESET_VAL=8'h5A).
// Directed table followed by a random regression against a behavioural model.
// Expected results are queued at drive time and popped after the clock edge.
module tb_jk_counter_bank;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_JK    = 2'b01;
  localparam logic [1:0] M_COUNT = 2'b10;
  localparam logic [1:0] M_LOAD  = 2'b11;
  localparam logic [7:0] MAXC    = 8'd9;
  localparam logic [7:0] RSTV    = 8'h5A;
  localparam int         NTBL    = 24;
  localparam int         NRAND   = 10000;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       up;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       tc;
  logic       wrap;

  jk_counter_bank #(
    .WIDTH    (8),
    .MAX_COUNT(9),
    .RESET_VAL('h5A)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .mode (mode),
    .up   (up),
    .j    (j),
    .k    (k),
    .q    (q),
    .qbar (qbar),
    .tc   (tc),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       up;
    logic [7:0] j;
    logic [7:0] k;
    logic       tc;
    logic [7:0] q;
    logic       wrap;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       wrap;
  } exp_t;

  vec_t tbl [NTBL];
  exp_t sb_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mq;
  logic       mwrap;

  function automatic vec_t mk(input logic rst, input logic e, input logic [1:0] m,
                              input logic u, input logic [7:0] jj, input logic [7:0] kk,
                              input logic etc, input logic [7:0] eq, input logic ew);
    vec_t v;
    v.rst = rst; v.en = e; v.mode = m; v.up = u; v.j = jj; v.k = kk;
    v.tc = etc; v.q = eq; v.wrap = ew;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: JK written as a per-bit truth table, counting with explicit compares.
  task automatic model_step(input logic rst, input logic e, input logic [1:0] m,
                            input logic u, input logic [7:0] jj, input logic [7:0] kk);
    if (rst) begin
      mq    = RSTV;
      mwrap = 1'b0;
    end else if (!e) begin
      mwrap = 1'b0;
    end else begin
      mwrap = 1'b0;
      case (m)
        M_JK: begin
          for (int i = 0; i < 8; i++) begin
            case ({jj[i], kk[i]})
              2'b10:   mq[i] = 1'b1;
              2'b01:   mq[i] = 1'b0;
              2'b11:   mq[i] = ~mq[i];
              default: mq[i] = mq[i];
            endcase
          end
        end
        M_COUNT: begin
          if (u) begin
            if (int'(mq) >= int'(MAXC)) begin mq = 8'd0; mwrap = 1'b1; end
            else mq = mq + 8'd1;
          end else begin
            if (mq == 8'd0) begin mq = MAXC; mwrap = 1'b1; end
            else mq = mq - 8'd1;
          end
        end
        M_LOAD:  mq = jj;
        default: mq = mq;
      endcase
    end
  endtask

  // One cycle: drive, check tc before the edge, queue expectations, pop and compare after the edge.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    reset = v.rst; en = v.en; mode = v.mode; up = v.up; j = v.j; k = v.k;
    #1;
    check({tag, ".tc"}, {7'd0, tc}, {7'd0, v.tc});
    e.q    = v.q;
    e.wrap = v.wrap;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.queue: got empty expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".q"}, q, e.q);
      check({tag, ".qbar"}, qbar, ~e.q);
      check({tag, ".wrap"}, {7'd0, wrap}, {7'd0, e.wrap});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    logic       r_rst, r_en, r_up, etc;
    logic [1:0] r_mode;
    logic [7:0] r_j, r_k;

    reset = 1'b0; en = 1'b0; mode = M_HOLD; up = 1'b0; j = 8'h00; k = 8'h00;

    //                 rst   en    mode     up    j      k      tc    q      wrap
    tbl[0]  = mk(1'b1, 1'b1, M_LOAD,  1'b0, 8'hFF, 8'h00, 1'b0, 8'h5A, 1'b0); // reset beats LOAD
    tbl[1]  = mk(1'b0, 1'b1, M_LOAD,  1'b0, 8'hCA, 8'h00, 1'b0, 8'hCA, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, M_JK,    1'b0, 8'hA6, 8'h6C, 1'b0, 8'hA6, 1'b0); // JK truth table
    tbl[3]  = mk(1'b0, 1'b1, M_JK,    1'b0, 8'hFF, 8'hFF, 1'b0, 8'h59, 1'b0); // all toggle
    tbl[4]  = mk(1'b0, 1'b1, M_HOLD,  1'b1, 8'h33, 8'hCC, 1'b0, 8'h59, 1'b0);
    tbl[5]  = mk(1'b0, 1'b1, M_LOAD,  1'b0, 8'h08, 8'h00, 1'b0, 8'h08, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, M_COUNT, 1'b1, 8'h00, 8'h00, 1'b0, 8'h09, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, M_COUNT, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1); // up wrap
    tbl[8]  = mk(1'b0, 1'b1, M_COUNT, 1'b1, 8'h00, 8'h00, 1'b0, 8'h01, 1'b0); // one-cycle pulse
    tbl[9]  = mk(1'b0, 1'b1, M_COUNT, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, M_COUNT, 1'b0, 8'h00, 8'h00, 1'b1, 8'h09, 1'b1); // down wrap
    tbl[11] = mk(1'b0, 1'b1, M_LOAD,  1'b0, 8'hC8, 8'h00, 1'b0, 8'hC8, 1'b0); // over-range load
    tbl[12] = mk(1'b0, 1'b1, M_COUNT, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1);
    tbl[13] = mk(1'b0, 1'b1, M_LOAD,  1'b0, 8'hC8, 8'h00, 1'b0, 8'hC8, 1'b0);
    tbl[14] = mk(1'b0, 1'b1, M_COUNT, 1'b0, 8'h00, 8'h00, 1'b0, 8'hC7, 1'b0); // plain decrement
    tbl[15] = mk(1'b0, 1'b1, M_LOAD,  1'b0, 8'h09, 8'h00, 1'b0, 8'h09, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, M_COUNT, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'h09, 1'b0); // en=0 masks tc
    tbl[17] = mk(1'b0, 1'b1, M_COUNT, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1);
    tbl[18] = mk(1'b0, 1'b0, M_COUNT, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0); // en=0 clears wrap
    tbl[19] = mk(1'b0, 1'b1, M_LOAD,  1'b0, 8'h09, 8'h00, 1'b0, 8'h09, 1'b0);
    tbl[20] = mk(1'b1, 1'b1, M_COUNT, 1'b1, 8'h00, 8'h00, 1'b1, 8'h5A, 1'b0); // reset on wrap edge
    tbl[21] = mk(1'b0, 1'b1, M_COUNT, 1'b0, 8'h00, 8'h00, 1'b0, 8'h59, 1'b0);
    tbl[22] = mk(1'b0, 1'b1, M_JK,    1'b0, 8'h00, 8'h00, 1'b0, 8'h59, 1'b0); // JK 00 holds
    tbl[23] = mk(1'b0, 1'b1, M_COUNT, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1); // 0x59 over range

    for (int i = 0; i < NTBL; i++) begin
      step(tbl[i], $sformatf("tbl%0d", i));
    end

    mq    = tbl[NTBL-1].q;
    mwrap = tbl[NTBL-1].wrap;

    for (int n = 0; n < NRAND; n++) begin
      r_rst  = ($urandom_range(0, 63) == 0);
      r_en   = ($urandom_range(0, 7) != 0);
      r_mode = 2'($urandom_range(0, 3));
      r_up   = 1'($urandom_range(0, 1));
      r_j    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
      r_k    = 8'($urandom_range(0, 255));
      etc    = r_en && (r_mode == M_COUNT) && (r_up ? (mq >= MAXC) : (mq == 8'd0));
      model_step(r_rst, r_en, r_mode, r_up, r_j, r_k);
      v = mk(r_rst, r_en, r_mode, r_up, r_j, r_k, etc, mq, mwrap);
      step(v, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
